// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator.
// Operand bit pairs arrive MSB-first, one pair per accepted beat. The first
// differing bit pair decides the result. Later pairs are still consumed so
// that the done pulse keeps a fixed beat count.
module serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic o1,
    output logic o2,
    output logic o3
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_count;
    logic          r_gt;
    logic          r_lt;
    logic          r_o1;
    logic          r_o2;
    logic          r_o3;

    logic w_launch;
    logic w_accept;
    logic w_last;
    logic w_undecided;
    logic w_gt_fin;
    logic w_lt_fin;

    // A new comparison may only be launched outside SHIFT.
    assign w_launch    = start && (r_state != S_SHIFT);
    assign w_accept    = (r_state == S_SHIFT) && bit_valid;
    assign w_last      = w_accept && (r_count == LAST_IDX);
    assign w_undecided = ~(r_gt | r_lt);
    // Once a decision is made it is frozen; otherwise the current pair decides.
    assign w_gt_fin    = w_undecided ? (a_bit & ~b_bit) : r_gt;
    assign w_lt_fin    = w_undecided ? (~a_bit & b_bit) : r_lt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE lasts one cycle and can chain straight into SHIFT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = w_launch ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit counter and running decision flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else if (w_launch) begin
            r_count <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else if (w_accept) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
            r_gt    <= w_gt_fin;
            r_lt    <= w_lt_fin;
        end
    end

    // Result registers; updated only when the final bit folds in, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o1 <= 1'b0;
            r_o2 <= 1'b0;
            r_o3 <= 1'b0;
        end else if (w_last) begin
            r_o1 <= w_gt_fin;
            r_o2 <= ~(w_gt_fin | w_lt_fin);
            r_o3 <= w_lt_fin;
        end
    end

    // Output decode straight from registered state and result flops.
    always_comb begin
        busy = (r_state == S_SHIFT);
        done = (r_state == S_DONE);
        o1   = r_o1;
        o2   = r_o2;
        o3   = r_o3;
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator: stimulus pushes the expected
// {gt,eq,lt} at launch, a monitor pops and compares on every done pulse.
module tb_serial_comparator;

    localparam int WIDTH = 8;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic start     = 1'b0;
    logic bit_valid = 1'b0;
    logic a_bit     = 1'b0;
    logic b_bit     = 1'b0;
    logic busy, done, o1, o2, o3;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] last_res = 3'b000;

    serial_comparator #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bit_valid(bit_valid),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .busy     (busy),
        .done     (done),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer magnitude comparison -> {gt, eq, lt}.
    function automatic logic [2:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // Monitor: reset values, result on done, hold between results.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_state", {busy, done, o1, o2, o3}, 5'b00000);
            last_res = 3'b000;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {4'b0000, done}, 5'b00000);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("result", {2'b00, o1, o2, o3}, {2'b00, e});
                $display("compare done: result gt/eq/lt=%b expected %b", {o1, o2, o3}, e);
                last_res = e;
            end
        end else begin
            check("hold", {2'b00, o1, o2, o3}, {2'b00, last_res});
        end
    end

    // One full comparison. Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit stall, input bit mid_start);
        exp_q.push_back(ref_model(a, b));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {4'b0000, busy}, 5'b00001);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (stall) begin
                int n;
                n = $urandom_range(0, 3);
                repeat (n) begin
                    bit_valid = 1'b0;
                    a_bit     = 1'($urandom_range(0, 1));
                    b_bit     = 1'($urandom_range(0, 1));
                    start     = mid_start && ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                    check("stall_busy", {3'b000, busy, done}, 5'b00010);
                end
            end
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            start     = mid_start;
            @(negedge clk);
            bit_valid = 1'b0;
            start     = 1'b0;
            if (i > 0) check("shift_busy", {3'b000, busy, done}, 5'b00010);
            else       check("done_timing", {3'b000, busy, done}, 5'b00001);
        end
    endtask

    // Start a comparison, feed some bits, then reset mid-flight.
    task automatic abort_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int nbits);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = WIDTH - 1; i > WIDTH - 1 - nbits; i--) begin
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_cmp(8'hA5, 8'hA5, 1'b0, 1'b0); @(negedge clk);
        run_cmp(8'h80, 8'h7F, 1'b0, 1'b0); @(negedge clk);
        run_cmp(8'h12, 8'h13, 1'b0, 1'b0); @(negedge clk);
        run_cmp(8'h3C, 8'h3B, 1'b1, 1'b0); @(negedge clk);
        abort_cmp(8'h55, 8'hAA, 4);
        run_cmp(8'h01, 8'h02, 1'b0, 1'b0); @(negedge clk);
        run_cmp(8'h5A, 8'h5A, 1'b0, 1'b1);
        run_cmp(8'hFF, 8'h00, 1'b0, 1'b0); @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: b = WIDTH'($urandom);
            endcase
            run_cmp(a, b, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("queue_drain", 5'(exp_q.size()), 5'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
